// File: rtl/prog_mem_loader_if.sv
//============================================================================
// Module   : prog_mem_loader_if
// Brief    : Loader byte stream and CPU memory bus for prog_mem_loader.
// Revision : 1.0
//============================================================================
`default_nettype none

interface prog_mem_loader_if #(
    parameter int AW = 6,
    parameter int DW = 8
);
    logic          ld_start;
    logic          ld_valid;
    logic [DW-1:0] ld_data;
    logic          ld_ready;
    logic          ld_done;
    logic          ld_err;
    logic          cpu_hold;
    logic [AW-1:0] address;
    logic          memWr;
    logic [DW-1:0] writedata;
    logic [DW-1:0] readdata;

    modport slave (
        input  ld_start, ld_valid, ld_data, address, memWr, writedata,
        output ld_ready, ld_done, ld_err, cpu_hold, readdata
    );

    modport master (
        output ld_start, ld_valid, ld_data, address, memWr, writedata,
        input  ld_ready, ld_done, ld_err, cpu_hold, readdata
    );
endinterface

`default_nettype wire

// File: rtl/prog_mem_loader.sv
//============================================================================
// Module   : prog_mem_loader
// Brief    : 64x8 CPU program/data memory with a byte-stream image loader
//            that holds the CPU in reset until the image is in place.
//            Optional trailer checksum: define MEM_CHECKSUM_EN.
// Revision : 1.0
//============================================================================
`default_nettype none

module prog_mem_loader #(
    parameter int AW       = 6,
    parameter int DW       = 8,
    parameter int DEPTH    = 64,
    parameter int LOAD_LEN = 64
) (
    input  wire               clk,
    input  wire               reset,
    prog_mem_loader_if.slave  bus
);

    localparam int            PTR_W    = AW + 1;
    localparam logic [AW:0]   PTR_LAST = PTR_W'(LOAD_LEN - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_RELEASE = 3'd2,
`ifdef MEM_CHECKSUM_EN
        ST_RUN     = 3'd3,
        ST_CHECK   = 3'd4,
        ST_ERROR   = 3'd5
`else
        ST_RUN     = 3'd3
`endif
    } state_t;

    state_t        state_q, state_d;
    logic [AW:0]   ptr_q, ptr_d;
    logic          ld_we;
    logic          cpu_we;
    logic [DW-1:0] mem_q [DEPTH];

`ifdef MEM_CHECKSUM_EN
    logic [DW-1:0] sum_q, sum_d;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
`ifdef MEM_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
`ifdef MEM_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ld_we   = 1'b0;
        cpu_we  = 1'b0;
`ifdef MEM_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        case (state_q)
            ST_LOAD: begin
                if (bus.ld_valid) begin
                    ld_we = 1'b1;
                    ptr_d = ptr_q + 1'b1;
`ifdef MEM_CHECKSUM_EN
                    sum_d = sum_q + bus.ld_data;
                    if (ptr_q == PTR_LAST) state_d = ST_CHECK;
`else
                    if (ptr_q == PTR_LAST) state_d = ST_RELEASE;
`endif
                end
            end
            ST_RELEASE: state_d = ST_RUN;
            ST_RUN:     cpu_we  = bus.memWr;
`ifdef MEM_CHECKSUM_EN
            ST_CHECK: begin
                if (bus.ld_valid)
                    state_d = (bus.ld_data == sum_q) ? ST_RELEASE : ST_ERROR;
            end
            ST_ERROR: state_d = ST_ERROR;
`endif
            default: state_d = state_q;
        endcase

        // A start pulse restarts the load from any state; it suppresses the
        // loader write of that cycle but not a CPU write issued in RUN.
        if (bus.ld_start) begin
            state_d = ST_LOAD;
            ptr_d   = '0;
            ld_we   = 1'b0;
`ifdef MEM_CHECKSUM_EN
            sum_d   = '0;
`endif
        end
    end

    // No reset on the array: a loaded image must survive a reset pulse.
    always_ff @(posedge clk) begin
        if (ld_we)
            mem_q[ptr_q[AW-1:0]] <= bus.ld_data;
        else if (cpu_we)
            mem_q[bus.address] <= bus.writedata;
    end

    assign bus.readdata = mem_q[bus.address];
    assign bus.ld_done  = (state_q == ST_RUN);
    assign bus.cpu_hold = (state_q != ST_RUN);

`ifdef MEM_CHECKSUM_EN
    assign bus.ld_ready = (state_q == ST_LOAD) || (state_q == ST_CHECK);
    assign bus.ld_err   = (state_q == ST_ERROR);
`else
    assign bus.ld_ready = (state_q == ST_LOAD);
    assign bus.ld_err   = 1'b0;
`endif

endmodule

`default_nettype wire
